cordic_phase_gen: RTL
=====================

# cordic_phase_gen

Phase-accumulator front end (NCO) that generates the 32-bit full-circle binary angle consumed by the combinational `cos_CORDIC` stage. It sits directly upstream of `cos_CORDIC`: software configures a frequency word, phase offset and sample-rate divider, and this block emits one registered angle per sample tick over a valid/ready handshake. The angle wraps naturally modulo 2^32, where 2^32 corresponds to 360°.

## Interface
- `PHASE_W`, 32, accumulator and angle width (binary angle, 2^PHASE_W = 360°)
- `DIV_W`, 16, sample-rate divider width
- `clock` in 1: single clock, all logic on the rising edge
- `reset_n` in 1: asynchronous, active-low reset
- `cfg_we` in 1: configuration write strobe, one cycle per write
- `cfg_addr` in 3: register select; 0 FREQ, 1 PHASE_OFS, 2 DIV, 3 CTRL, 4 STEP, 5 FREQ_STOP
- `cfg_wdata` in 32: write data; DIV uses bits [DIV_W-1:0], CTRL uses bit0 = enable and bit1 = clear_phase (self-clearing)
- `angle` out PHASE_W: angle to `cos_CORDIC`, held stable while `angle_valid && !angle_ready`
- `angle_valid` out 1: sample available
- `angle_ready` in 1: downstream accepts the sample
- `running` out 1: FSM is in RUN
- `overrun` out 1: sticky flag; set when a tick occurs while a sample is stalled; cleared by a CTRL write

## Operation
- Reset values: acc=0, FREQ=0, PHASE_OFS=0, DIV=0, enable=0, cnt=0; `angle`=0, `angle_valid`=0, `running`=0, `overrun`=0.
- FSM states:
  - IDLE → RUN on a CTRL write with bit0=1.
  - RUN → IDLE on a CTRL write with bit0=0.
  - Entering RUN sets cnt=0. Entering IDLE clears cnt and `angle_valid` on the next edge; acc is retained.
- Tick: asserted in any RUN cycle where cnt==DIV. cnt then returns to 0; otherwise cnt increments. DIV=0 gives a tick every RUN cycle.
- On tick:
  - acc ← acc + freq_cur, mod 2^PHASE_W.
  - If the output is free (`!angle_valid` or `angle_ready`): `angle` ← acc_old + PHASE_OFS, mod 2^PHASE_W, and `angle_valid`=1. The emitted angle is the pre-increment phase.
  - If the output is stalled: the sample is dropped, `overrun` ← 1, `angle` is unchanged, and acc still advances so phase stays continuous in time.
- Handshake:
  - Transfer occurs when valid && ready.
  - Without a new tick in the same cycle, `angle_valid` drops on the next edge.
  - A tick coinciding with a transfer loads the new sample back-to-back.
- clear_phase: acc ← 0 on the next edge and has priority over the tick increment. A coincident tick emits angle = PHASE_OFS.
- A FREQ write takes effect for the next tick. A same-cycle tick uses the old value. A FREQ write also reloads freq_cur.
- A CTRL write is atomic: enable update and overrun clear happen on the same edge.

## Timing
- Output is registered; no combinational path from `angle_ready` to `angle`/`angle_valid`.
- CTRL enable write at edge N, DIV=D: first `angle_valid` rises at edge N+D+2. Steady state gives one sample per D+1 cycles.
- The downstream `cos_CORDIC` is combinational, so cosine is valid in the same cycle as `angle_valid`.

## Configuration
- Macro `CORDIC_PHASE_SWEEP_EN`, defined: linear chirp.
  - On each tick, after the acc update: freq_cur ← freq_cur + STEP.
  - If the 33-bit unsigned sum exceeds FREQ_STOP, freq_cur ← FREQ instead (sweep wraps to its start).
  - STEP and FREQ_STOP reset to 0.
- Not defined: freq_cur ≡ FREQ. Writes to addresses 4 and 5 are ignored, and no sweep logic is synthesised.

## Structure
- Shared package `cordic_pkg`: the register address constants, the CTRL bit positions, the FSM state typedef {IDLE, RUN}, and PHASE_W.
- One sub-module, `cordic_tick_div`: divider counter producing the tick, cleared on RUN entry.
- `cordic_phase_gen` instantiates `cordic_tick_div` and drives `cos_CORDIC.angle`.

## Test plan
- Reset, then FREQ=0x0100_0000, DIV=0, enable, ready held at 1: angles 0x0, 0x0100_0000, 0x0200_0000, …; wraps to 0 after 256 samples.
- PHASE_OFS=0x4000_0000, FREQ=0, enable: every angle equals 0x4000_0000, and the CORDIC cosine is ≈0.
- DIV=3, ready=1: `angle_valid` pulses once every 4 cycles; first pulse arrives at edge N+5 after the enable write at edge N.
- ready=0 for 10 ticks with DIV=0: `angle` holds the first sample and `overrun`=1. After ready rises, the next angle reflects 11·FREQ advance. A CTRL write clears `overrun`.
- clear_phase and a tick in the same cycle, with PHASE_OFS=0x10: emitted angle is 0x10; the next is 0x10+FREQ. Also: `reset_n` asserted mid-run forces all outputs to 0 asynchronously.
- With `CORDIC_PHASE_SWEEP_EN` defined, FREQ=10, STEP=5, FREQ_STOP=20: freq_cur sequence is 10, 15, 20, 10, …

Source files
------------

// File: rtl/cordic_phase_gen_pkg.sv
// Shared definitions for the cordic_phase_gen NCO front end: register map,
// CTRL bit positions, FSM state type and default widths.
package cordic_pkg;

  localparam int PHASE_W = 32;
  localparam int DIV_W   = 16;

  // Configuration register addresses
  localparam logic [2:0] ADDR_FREQ      = 3'd0;
  localparam logic [2:0] ADDR_PHASE_OFS = 3'd1;
  localparam logic [2:0] ADDR_DIV       = 3'd2;
  localparam logic [2:0] ADDR_CTRL      = 3'd3;
  localparam logic [2:0] ADDR_STEP      = 3'd4;
  localparam logic [2:0] ADDR_FREQ_STOP = 3'd5;

  // CTRL register bits
  localparam int CTRL_EN_BIT  = 0;
  localparam int CTRL_CLR_BIT = 1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } phase_state_e;

endpackage

// File: rtl/cordic_phase_gen_if.sv
// Angle stream from the NCO to the combinational cos_CORDIC stage.
//
// Handshake: a sample transfers on any rising edge where angle_valid and
// angle_ready are both high. The master holds angle stable and keeps
// angle_valid high until the transfer; the slave may assert angle_ready at
// any time, independently of angle_valid.
interface cordic_phase_gen_if #(
  parameter int PHASE_W = cordic_pkg::PHASE_W
);
  logic [PHASE_W-1:0] angle;
  logic               angle_valid;
  logic               angle_ready;

  modport master (output angle, output angle_valid, input angle_ready);
  modport slave  (input angle, input angle_valid, output angle_ready);
endinterface

// File: rtl/cordic_tick_div.sv
// Sample-rate divider: produces a registered one-cycle tick every DIV+1
// enabled cycles. Counter and tick are cleared whenever the block is not
// enabled, so every RUN entry starts counting from zero.
module cordic_tick_div #(
  parameter int DIV_W = cordic_pkg::DIV_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             tick_o
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;

  // Next count: wrap to zero and raise tick when the count reaches DIV
  always_comb begin
    cnt_d  = '0;
    tick_d = 1'b0;
    if (en_i) begin
      if (cnt_q == div_i) begin
        tick_d = 1'b1;
      end else begin
        cnt_d = cnt_q + DIV_W'(1);
      end
    end
  end

  // Counter and tick registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick_o = tick_q;

endmodule

// File: rtl/cordic_phase_gen.sv
// Phase accumulator (NCO) feeding cos_CORDIC with one registered binary
// angle per sample tick over a valid/ready stream.
// Optional feature macro: CORDIC_PHASE_SWEEP_EN (linear frequency chirp
// using the STEP and FREQ_STOP registers).
module cordic_phase_gen #(
  parameter int PHASE_W = cordic_pkg::PHASE_W,
  parameter int DIV_W   = cordic_pkg::DIV_W
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     cfg_we,
  input  logic [2:0]               cfg_addr,
  input  logic [31:0]              cfg_wdata,
  cordic_phase_gen_if.master       out_if,
  output logic                     running,
  output logic                     overrun,
  output cordic_pkg::phase_state_e dbg_state
);

  import cordic_pkg::*;

  phase_state_e       state_q, state_d;
  logic [PHASE_W-1:0] freq_q, phase_ofs_q, acc_q, acc_d, angle_q, angle_d;
  logic [DIV_W-1:0]   div_q;
  logic               valid_q, valid_d, overrun_q, overrun_d;
  logic [PHASE_W-1:0] freq_cur, acc_base;
  logic               ctrl_we, ctrl_en, ctrl_clr, tick_raw, tick, out_free;

  assign ctrl_we  = cfg_we && (cfg_addr == ADDR_CTRL);
  assign ctrl_en  = cfg_wdata[CTRL_EN_BIT];
  assign ctrl_clr = cfg_wdata[CTRL_CLR_BIT];

  // Configuration registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      freq_q      <= '0;
      phase_ofs_q <= '0;
      div_q       <= '0;
    end else if (cfg_we) begin
      case (cfg_addr)
        ADDR_FREQ:      freq_q      <= cfg_wdata[PHASE_W-1:0];
        ADDR_PHASE_OFS: phase_ofs_q <= cfg_wdata[PHASE_W-1:0];
        ADDR_DIV:       div_q       <= cfg_wdata[DIV_W-1:0];
        default: ;
      endcase
    end
  end

`ifdef CORDIC_PHASE_SWEEP_EN
  logic [PHASE_W-1:0] step_q, freq_stop_q, freq_cur_q;
  logic [PHASE_W:0]   sweep_sum;

  assign sweep_sum = {1'b0, freq_cur_q} + {1'b0, step_q};
  assign freq_cur  = freq_cur_q;

  // Chirp registers; a FREQ write restarts the sweep from the new start
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      step_q      <= '0;
      freq_stop_q <= '0;
      freq_cur_q  <= '0;
    end else begin
      if (cfg_we && cfg_addr == ADDR_STEP)      step_q      <= cfg_wdata[PHASE_W-1:0];
      if (cfg_we && cfg_addr == ADDR_FREQ_STOP) freq_stop_q <= cfg_wdata[PHASE_W-1:0];
      if (cfg_we && cfg_addr == ADDR_FREQ) begin
        freq_cur_q <= cfg_wdata[PHASE_W-1:0];
      end else if (tick) begin
        freq_cur_q <= (sweep_sum > {1'b0, freq_stop_q}) ? freq_q : sweep_sum[PHASE_W-1:0];
      end
    end
  end
`else
  assign freq_cur = freq_q;
`endif

  // FSM next state: only a CTRL write moves between IDLE and RUN
  always_comb begin
    state_d = state_q;
    if (ctrl_we) begin
      state_d = ctrl_en ? RUN : IDLE;
    end
  end

  // FSM state register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  cordic_tick_div #(.DIV_W(DIV_W)) u_tick_div (
    .clk    (clock),
    .rst_n  (reset_n),
    .en_i   (state_q == RUN),
    .div_i  (div_q),
    .tick_o (tick_raw)
  );

  // A tick registered in the last RUN cycle must not fire once in IDLE
  assign tick     = tick_raw && (state_q == RUN);
  assign out_free = !valid_q || out_if.angle_ready;

  // clear_phase makes this cycle's phase zero; a coincident tick then emits
  // PHASE_OFS and advances from zero, keeping the next sample at OFS+FREQ.
  assign acc_base = (ctrl_we && ctrl_clr) ? '0 : acc_q;

  // Accumulator, output sample and overrun next-state
  always_comb begin
    acc_d     = acc_q;
    angle_d   = angle_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    if (valid_q && out_if.angle_ready) valid_d = 1'b0;
    if (ctrl_we && ctrl_clr) acc_d = '0;
    if (tick) begin
      acc_d = acc_base + freq_cur;
      if (out_free) begin
        angle_d = acc_base + phase_ofs_q;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
    if (ctrl_we) overrun_d = 1'b0;
    if (state_d == IDLE) valid_d = 1'b0;
  end

  // Datapath registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      acc_q     <= '0;
      angle_q   <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      angle_q   <= angle_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign out_if.angle       = angle_q;
  assign out_if.angle_valid = valid_q;
  assign running            = (state_q == RUN);
  assign overrun            = overrun_q;
  assign dbg_state          = state_q;

endmodule
